dda_stepper: RTL and testbench
==============================

DDA_STEPPER -- requirements
Module: dda_stepper

Interface
REQ-001 Parameter W, default 32: width of unsigned tMax/tDelta distances.
REQ-002 Parameter CW, default 6: voxel coordinate width; grid spans 0..2^CW-1 per axis.
REQ-003 Parameter MAX_STEPS, default 128: maximum voxels emitted per ray.
REQ-004 clk  in  1: single clock, rising-edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 ray_valid / ray_ready  in / out  1: ray-load handshake.
REQ-007 ix0, iy0, iz0  in  CW each: start voxel.
REQ-008 sneg  in  3: per-axis step direction, [0]=x, [1]=y, [2]=z; 1=decrement, 0=increment.
REQ-009 tmax0_x/y/z, tdelta_x/y/z  in  W each: initial tMax and per-axis tDelta.
REQ-010 abort  in  1: synchronous cancel of the current ray.
REQ-011 vox_valid / vox_ready  out / in  1: visited-voxel output handshake.
REQ-012 vox_x, vox_y, vox_z  out  CW each: visited voxel coordinate.
REQ-013 done  out  1: one-cycle pulse at ray termination.
REQ-014 done_reason  out  1: 0=EXIT (left grid), 1=MAXSTEP.
REQ-015 done_steps  out  $clog2(MAX_STEPS+1): voxels emitted for the ray; valid while done=1.

Function
REQ-016 FSM states: IDLE, EMIT, STEP, DONE.
REQ-017 ray_ready SHALL equal (state==IDLE).
REQ-018 IDLE: on ray_valid, latch start voxel, sneg, tmax0, tdelta; clear step count; go to EMIT.
REQ-019 EMIT: vox_valid=1 and vox_x/y/z = current voxel; outputs held stable until vox_ready.
REQ-020 EMIT with vox_ready: increment step count; go to DONE (reason MAXSTEP) if the count reaches MAX_STEPS, else to STEP.
REQ-021 STEP: an axis_choose instance on the three tMax registers yields step_mask.
REQ-022 STEP: every axis with its mask bit set steps its coordinate by ±1 per sneg, and its tMax gains tdelta; ties step multiple axes in the same cycle.
REQ-023 tMax addition SHALL saturate at 2^W-1.
REQ-024 Exit check: stepping an axis at 0 with sneg=1, or at 2^CW-1 with sneg=0, is an exit.
REQ-025 On exit: go to DONE with reason EXIT, coordinates unchanged, no wrap-around.
REQ-026 STEP with no exit: go to EMIT; STEP lasts exactly one cycle.
REQ-027 Per non-exiting step, latency from vox_ready handshake to next vox_valid is 2 cycles.
REQ-028 DONE: done=1 for one cycle with done_reason and done_steps; then IDLE.
REQ-029 abort in any non-IDLE state returns to IDLE next cycle; no done pulse; abort in IDLE is ignored.
REQ-030 abort has priority over the handshake in the same cycle: a simultaneous vox_ready is not counted as a transfer.
REQ-031 vox_valid, done, done_reason, done_steps SHALL be 0 outside the states that drive them.

Reset
REQ-032 rst_n low asynchronously forces IDLE; all datapath registers cleared to 0.
REQ-033 While rst_n is low, vox_valid=0 and done=0; ray_ready follows REQ-017.
REQ-034 Reset mid-ray discards the ray with no done pulse.

Structure
REQ-035 A shared package holds the state enum, the done_reason encoding, and the default W/CW.
REQ-036 The sole sub-module is the existing axis_choose (W-bit), instantiated once; primary_sel is left unused.

Verification
REQ-037 Start (5,5,5), sneg=000, tmax0=(10,20,30), tdelta=(10,100,100), MAX_STEPS=4, vox_ready=1 -> emits (5,5,5), (6,5,5), (7,6,5), (8,6,6); done, reason=MAXSTEP, steps=4.
REQ-038 Start (0,3,3), sneg=001, tmax0=(1,50,50) -> emits (0,3,3) only; done, reason=EXIT, steps=1.
REQ-039 vox_ready held low 5 cycles in EMIT -> vox_valid and coordinates stable, tMax registers unchanged.
REQ-040 tmax0_x=0xFFFFFFF0, tdelta_x=0x20, x minimal -> tMax_x becomes 0xFFFFFFFF after the step.
REQ-041 abort asserted with vox_ready in EMIT -> IDLE next cycle, ray_ready=1, no done pulse, transfer not counted.
REQ-042 rst_n low mid-STEP -> immediate IDLE, vox_valid=0; a new ray after reset runs normally.

Source files
------------

// File: rtl/dda_stepper_pkg.sv
// Shared types and default widths for the 3D DDA voxel stepper.
package dda_stepper_pkg;

  localparam int DDA_W_DEFAULT  = 32;
  localparam int DDA_CW_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    REASON_EXIT    = 1'b0,
    REASON_MAXSTEP = 1'b1
  } reason_e;

endpackage

// File: rtl/dda_stepper_axis_choose.sv
// Picks the axis (or tied axes) with the smallest tMax; primary_sel is the lowest-index minimum.
module axis_choose #(
  parameter int W = 32
) (
  input  logic [W-1:0] tmax_x,
  input  logic [W-1:0] tmax_y,
  input  logic [W-1:0] tmax_z,
  output logic [2:0]   step_mask,
  output logic [1:0]   primary_sel
);

  logic x_le_y, x_le_z, y_le_z;

  always_comb begin
    x_le_y = (tmax_x <= tmax_y);
    x_le_z = (tmax_x <= tmax_z);
    y_le_z = (tmax_y <= tmax_z);

    step_mask[0] = x_le_y && x_le_z;
    step_mask[1] = (tmax_y <= tmax_x) && y_le_z;
    step_mask[2] = (tmax_z <= tmax_x) && (tmax_z <= tmax_y);

    primary_sel = 2'd2;
    if (step_mask[0]) begin
      primary_sel = 2'd0;
    end else if (step_mask[1]) begin
      primary_sel = 2'd1;
    end
  end

endmodule

// File: rtl/dda_stepper.sv
// Amanatides-Woo style voxel walker: emits each visited voxel, then steps the minimum-tMax axes.
module dda_stepper
  import dda_stepper_pkg::*;
#(
  parameter int W         = DDA_W_DEFAULT,
  parameter int CW        = DDA_CW_DEFAULT,
  parameter int MAX_STEPS = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ray_valid,
  output logic                             ray_ready,
  input  logic [CW-1:0]                    ix0,
  input  logic [CW-1:0]                    iy0,
  input  logic [CW-1:0]                    iz0,
  input  logic [2:0]                       sneg,
  input  logic [W-1:0]                     tmax0_x,
  input  logic [W-1:0]                     tmax0_y,
  input  logic [W-1:0]                     tmax0_z,
  input  logic [W-1:0]                     tdelta_x,
  input  logic [W-1:0]                     tdelta_y,
  input  logic [W-1:0]                     tdelta_z,
  input  logic                             abort,
  output logic                             vox_valid,
  input  logic                             vox_ready,
  output logic [CW-1:0]                    vox_x,
  output logic [CW-1:0]                    vox_y,
  output logic [CW-1:0]                    vox_z,
  output logic                             done,
  output logic                             done_reason,
  output logic [$clog2(MAX_STEPS+1)-1:0]   done_steps
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  function automatic logic [CW-1:0] step_coord(input logic [CW-1:0] c, input logic neg);
    return neg ? (c - CW'(1)) : (c + CW'(1));
  endfunction

  function automatic logic at_edge(input logic [CW-1:0] c, input logic neg);
    return neg ? (c == '0) : (c == {CW{1'b1}});
  endfunction

  state_e        state_q, state_d;
  reason_e       reason_q, reason_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [2:0]    sneg_q, sneg_d;
  logic [W-1:0]  tmx_q, tmx_d, tmy_q, tmy_d, tmz_q, tmz_d;
  logic [W-1:0]  tdx_q, tdx_d, tdy_q, tdy_d, tdz_q, tdz_d;
  logic [SW-1:0] steps_q, steps_d, steps_inc;

  logic [2:0]    step_mask;
  logic [1:0]    unused_primary_sel;
  logic [2:0]    edge_hit;
  logic          exit_hit;

  axis_choose #(.W(W)) u_axis_choose (
    .tmax_x      (tmx_q),
    .tmax_y      (tmy_q),
    .tmax_z      (tmz_q),
    .step_mask   (step_mask),
    .primary_sel (unused_primary_sel)
  );

  // An exit is any masked axis that would leave the grid; nothing moves in that case.
  always_comb begin
    edge_hit[0] = at_edge(x_q, sneg_q[0]);
    edge_hit[1] = at_edge(y_q, sneg_q[1]);
    edge_hit[2] = at_edge(z_q, sneg_q[2]);
    exit_hit    = |(step_mask & edge_hit);
    steps_inc   = steps_q + SW'(1);
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    sneg_d   = sneg_q;
    tmx_d    = tmx_q;
    tmy_d    = tmy_q;
    tmz_d    = tmz_q;
    tdx_d    = tdx_q;
    tdy_d    = tdy_q;
    tdz_d    = tdz_q;
    steps_d  = steps_q;

    case (state_q)
      ST_IDLE: begin
        if (ray_valid) begin
          x_d      = ix0;
          y_d      = iy0;
          z_d      = iz0;
          sneg_d   = sneg;
          tmx_d    = tmax0_x;
          tmy_d    = tmax0_y;
          tmz_d    = tmax0_z;
          tdx_d    = tdelta_x;
          tdy_d    = tdelta_y;
          tdz_d    = tdelta_z;
          steps_d  = '0;
          reason_d = REASON_EXIT;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (vox_ready) begin
          steps_d = steps_inc;
          if (steps_inc == SW'(MAX_STEPS)) begin
            reason_d = REASON_MAXSTEP;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (exit_hit) begin
          reason_d = REASON_EXIT;
          state_d  = ST_DONE;
        end else begin
          if (step_mask[0]) begin
            x_d   = step_coord(x_q, sneg_q[0]);
            tmx_d = sat_add(tmx_q, tdx_q);
          end
          if (step_mask[1]) begin
            y_d   = step_coord(y_q, sneg_q[1]);
            tmy_d = sat_add(tmy_q, tdy_q);
          end
          if (step_mask[2]) begin
            z_d   = step_coord(z_q, sneg_q[2]);
            tmz_d = sat_add(tmz_q, tdz_q);
          end
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reason_q <= REASON_EXIT;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      sneg_q   <= '0;
      tmx_q    <= '0;
      tmy_q    <= '0;
      tmz_q    <= '0;
      tdx_q    <= '0;
      tdy_q    <= '0;
      tdz_q    <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      sneg_q   <= sneg_d;
      tmx_q    <= tmx_d;
      tmy_q    <= tmy_d;
      tmz_q    <= tmz_d;
      tdx_q    <= tdx_d;
      tdy_q    <= tdy_d;
      tdz_q    <= tdz_d;
      steps_q  <= steps_d;
    end
  end

  // Outputs decode straight from the state register, so they are glitch-free.
  always_comb begin
    ray_ready   = (state_q == ST_IDLE);
    vox_valid   = (state_q == ST_EMIT);
    done        = (state_q == ST_DONE);
    done_reason = (state_q == ST_DONE) ? reason_q : 1'b0;
    done_steps  = (state_q == ST_DONE) ? steps_q : '0;
    vox_x       = x_q;
    vox_y       = y_q;
    vox_z       = z_q;
  end

endmodule

// File: tb/tb_dda_stepper.sv
// Directed bench for dda_stepper with MAX_STEPS=4; expected voxels worked out by hand.
module tb_dda_stepper;

  localparam int W  = 32;
  localparam int CW = 6;
  localparam int MS = 4;
  localparam int SW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ray_valid;
  logic          ray_ready;
  logic [CW-1:0] ix0, iy0, iz0;
  logic [2:0]    sneg;
  logic [W-1:0]  tmax0_x, tmax0_y, tmax0_z;
  logic [W-1:0]  tdelta_x, tdelta_y, tdelta_z;
  logic          abort;
  logic          vox_valid;
  logic          vox_ready;
  logic [CW-1:0] vox_x, vox_y, vox_z;
  logic          done;
  logic          done_reason;
  logic [SW-1:0] done_steps;

  int total = 0;
  int bad   = 0;

  dda_stepper #(.W(W), .CW(CW), .MAX_STEPS(MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ray_valid   (ray_valid),
    .ray_ready   (ray_ready),
    .ix0         (ix0),
    .iy0         (iy0),
    .iz0         (iz0),
    .sneg        (sneg),
    .tmax0_x     (tmax0_x),
    .tmax0_y     (tmax0_y),
    .tmax0_z     (tmax0_z),
    .tdelta_x    (tdelta_x),
    .tdelta_y    (tdelta_y),
    .tdelta_z    (tdelta_z),
    .abort       (abort),
    .vox_valid   (vox_valid),
    .vox_ready   (vox_ready),
    .vox_x       (vox_x),
    .vox_y       (vox_y),
    .vox_z       (vox_z),
    .done        (done),
    .done_reason (done_reason),
    .done_steps  (done_steps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [CW-1:0] z,
                        input logic [2:0] s,
                        input logic [W-1:0] tx, input logic [W-1:0] ty, input logic [W-1:0] tz,
                        input logic [W-1:0] dx, input logic [W-1:0] dy, input logic [W-1:0] dz);
    ix0 = x; iy0 = y; iz0 = z; sneg = s;
    tmax0_x = tx; tmax0_y = ty; tmax0_z = tz;
    tdelta_x = dx; tdelta_y = dy; tdelta_z = dz;
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic expect_vox(input logic [CW-1:0] ex, input logic [CW-1:0] ey, input logic [CW-1:0] ez,
                            input string tag, output int waits);
    logic got;
    got   = 1'b0;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      if (vox_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      waits++;
    end
    chk({tag, "_vld"}, 64'(got), 64'd1);
    chk(tag, 64'({vox_x, vox_y, vox_z}), 64'({ex, ey, ez}));
    if (vox_ready) @(negedge clk);
  endtask

  task automatic expect_done(input logic reason, input int steps, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_reason"}, 64'(done_reason), 64'(reason));
    chk({tag, "_steps"}, 64'(done_steps), 64'(steps));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({done, ray_ready, done_reason, done_steps}), 64'({1'b0, 1'b1, 1'b0, {SW{1'b0}}}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; ray_valid = 1'b0; abort = 1'b0; vox_ready = 1'b1;
    ix0 = '0; iy0 = '0; iz0 = '0; sneg = '0;
    tmax0_x = '0; tmax0_y = '0; tmax0_z = '0;
    tdelta_x = '0; tdelta_y = '0; tdelta_z = '0;

    repeat (2) @(negedge clk);
    chk("rst_vox_valid", 64'(vox_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ray_ready", 64'(ray_ready), 64'd1);
    chk("rst_done_steps", 64'(done_steps), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ties step several axes together; stops on MAX_STEPS.
    launch(6'd5, 6'd5, 6'd5, 3'b000, 32'd10, 32'd20, 32'd30, 32'd10, 32'd100, 32'd100);
    expect_vox(6'd5, 6'd5, 6'd5, "t1_v0", n);
    expect_vox(6'd6, 6'd5, 6'd5, "t1_v1", n);
    chk("t1_latency", 64'(n), 64'd1);
    expect_vox(6'd7, 6'd6, 6'd5, "t1_v2", n);
    expect_vox(6'd8, 6'd6, 6'd6, "t1_v3", n);
    chk("t1_latency3", 64'(n), 64'd1);
    expect_done(1'b1, 4, "t1");

    // Leaving at x=0 with decrement.
    launch(6'd0, 6'd3, 6'd3, 3'b001, 32'd1, 32'd50, 32'd50, 32'd1, 32'd1, 32'd1);
    expect_vox(6'd0, 6'd3, 6'd3, "t2_v0", n);
    expect_done(1'b0, 1, "t2");

    // Leaving at x=63 with increment.
    launch(6'd63, 6'd0, 6'd0, 3'b000, 32'd1, 32'd2, 32'd3, 32'd1, 32'd1, 32'd1);
    expect_vox(6'd63, 6'd0, 6'd0, "t2b_v0", n);
    expect_done(1'b0, 1, "t2b");

    // Back-pressure: five stalled cycles must not disturb anything.
    vox_ready = 1'b0;
    launch(6'd20, 6'd20, 6'd20, 3'b000, 32'd5, 32'd7, 32'd9, 32'd100, 32'd100, 32'd100);
    expect_vox(6'd20, 6'd20, 6'd20, "t3_v0", n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall", 64'({vox_valid, vox_x, vox_y, vox_z}), 64'({1'b1, 6'd20, 6'd20, 6'd20}));
    end
    vox_ready = 1'b1;
    @(negedge clk);
    expect_vox(6'd21, 6'd20, 6'd20, "t3_v1", n);
    expect_vox(6'd21, 6'd21, 6'd20, "t3_v2", n);
    expect_vox(6'd21, 6'd21, 6'd21, "t3_v3", n);
    expect_done(1'b1, 4, "t3");

    // Saturation: x saturates to all-ones and then ties with y and z.
    launch(6'd10, 6'd10, 6'd10, 3'b000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h20, 32'd1, 32'd1);
    expect_vox(6'd10, 6'd10, 6'd10, "t4_v0", n);
    expect_vox(6'd11, 6'd10, 6'd10, "t4_v1", n);
    expect_vox(6'd12, 6'd11, 6'd11, "t4_v2", n);
    expect_vox(6'd13, 6'd12, 6'd12, "t4_v3", n);
    expect_done(1'b1, 4, "t4");

    // All axes decrementing.
    launch(6'd5, 6'd5, 6'd5, 3'b111, 32'd3, 32'd3, 32'd9, 32'd10, 32'd10, 32'd10);
    expect_vox(6'd5, 6'd5, 6'd5, "t5_v0", n);
    expect_vox(6'd4, 6'd4, 6'd5, "t5_v1", n);
    expect_vox(6'd4, 6'd4, 6'd4, "t5_v2", n);
    expect_vox(6'd3, 6'd3, 6'd4, "t5_v3", n);
    expect_done(1'b1, 4, "t5");

    // Abort in IDLE is ignored; abort with vox_ready in EMIT wins.
    abort = 1'b1;
    launch(6'd30, 6'd30, 6'd30, 3'b000, 32'd1, 32'd2, 32'd3, 32'd1, 32'd1, 32'd1);
    chk("t6_idle_abort", 64'({vox_valid, vox_x}), 64'({1'b1, 6'd30}));
    @(negedge clk);
    abort = 1'b0;
    chk("t6_abort", 64'({ray_ready, vox_valid, done}), 64'({1'b1, 1'b0, 1'b0}));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || vox_valid) seen = 1'b1;
    end
    chk("t6_no_done", 64'(seen), 64'd0);

    // Reset while in STEP discards the ray; the next ray runs normally.
    launch(6'd40, 6'd40, 6'd40, 3'b000, 32'd1, 32'd2, 32'd3, 32'd1, 32'd1, 32'd1);
    expect_vox(6'd40, 6'd40, 6'd40, "t7_v0", n);
    rst_n = 1'b0;
    #1;
    chk("t7_rst", 64'({vox_valid, ray_ready, done}), 64'({1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || vox_valid) seen = 1'b1;
    end
    chk("t7_quiet", 64'(seen), 64'd0);
    launch(6'd0, 6'd3, 6'd3, 3'b001, 32'd1, 32'd50, 32'd50, 32'd1, 32'd1, 32'd1);
    expect_vox(6'd0, 6'd3, 6'd3, "t7_v1", n);
    expect_done(1'b0, 1, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
